// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver with 16x oversampling: start bit checked at mid-bit, data at mid-bit.
// Byte appears one cycle after the stop-bit sample; no backpressure, o_rx_done is a single-cycle strobe.
module uart_rx_sampler #(
  parameter int NB_DATA    = 8,
  parameter int N_SB_TICK  = 16,
  parameter int N_TICK_BIT = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx,
  input  logic               i_tick,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_error
);

  localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [3:0]    START_MID = 4'd7;
  localparam logic [3:0]    BIT_LAST  = 4'(N_TICK_BIT - 1);
  localparam logic [3:0]    STOP_LAST = 4'(N_SB_TICK - 1);
  localparam logic [BW-1:0] CNT_LAST  = BW'(NB_DATA - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             state_q, state_d;
  logic               rx_meta_q, rx_s_q;
  logic [3:0]         tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               done_q, done_d;
  logic               ferr_q, ferr_d;

  // Synchronizer resets to the idle line level so reset release never looks like a start bit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Start detection ignores i_tick; a coincident tick is deliberately not counted.
        if (!rx_s_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
        end
      end
      S_START: begin
        if (i_tick) begin
          if (tick_cnt_q == START_MID) begin
            if (!rx_s_q) begin
              state_d    = S_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (i_tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            shift_d    = {rx_s_q, shift_q[NB_DATA-1:1]};
            tick_cnt_d = '0;
            if (bit_cnt_q == CNT_LAST) state_d = S_STOP;
            else                       bit_cnt_d = bit_cnt_q + BW'(1);
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (i_tick) begin
          if (tick_cnt_q == STOP_LAST) begin
            state_d = S_IDLE;
            if (rx_s_q) begin
              data_d = shift_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_data        = data_q;
  assign o_rx_done     = done_q;
  assign o_frame_error = ferr_q;

endmodule
